// File: rtl/id_ex_stage_pkg.sv
// Shared MIPS decode definitions: opcodes, control-bundle layout and small helpers.
// Used by the ID/EX stage, its interface and the load-use detector.
package mips_pkg;

   localparam int CTRL_W  = 8;
   localparam int ALUOP_W = 3;

   localparam logic [5:0] RTYPE = 6'b000000;
   localparam logic [5:0] LW    = 6'b100011;
   localparam logic [5:0] SW    = 6'b101011;
   localparam logic [5:0] BEQ   = 6'b000100;
   localparam logic [5:0] J     = 6'b000010;

   localparam int CTRL_REGDST   = 7;
   localparam int CTRL_REGWRITE = 6;
   localparam int CTRL_ALUSRC   = 5;
   localparam int CTRL_MEMREAD  = 4;
   localparam int CTRL_MEMWRITE = 3;
   localparam int CTRL_MEMTOREG = 2;
   localparam int CTRL_BRANCH   = 1;
   localparam int CTRL_JUMP     = 0;

   typedef struct packed {
      logic regdst;
      logic regwrite;
      logic alusrc;
      logic memread;
      logic memwrite;
      logic memtoreg;
      logic branch;
      logic jump;
   } ctrl_t;

   // Instructions whose rt field is a source operand (not a destination).
   function automatic logic uses_rt(input logic [5:0] opcode);
      return (opcode == RTYPE) || (opcode == BEQ) || (opcode == SW);
   endfunction

   // The control unit leaves don't-care bits as X for sw/j; any bit that can
   // commit architectural state is forced to 0 if unknown. Hardware sees a
   // straight copy because the X test is never true for real logic levels.
   function automatic ctrl_t sanitize_ctrl(input ctrl_t c);
      ctrl_t s;
      s = c;
      if ((^c.regwrite) === 1'bx) s.regwrite = 1'b0;
      if ((^c.memread)  === 1'bx) s.memread  = 1'b0;
      if ((^c.memwrite) === 1'bx) s.memwrite = 1'b0;
      if ((^c.branch)   === 1'bx) s.branch   = 1'b0;
      if ((^c.jump)     === 1'bx) s.jump     = 1'b0;
      return s;
   endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-to-EX bus: decoded ID fields and flush in, registered EX bundle and stall out.
// master = upstream/driver side, slave = the ID/EX stage.
interface id_ex_stage_if
   import mips_pkg::*;
#(
   parameter int DW = 32,
   parameter int RW = 5
) ();

   logic [31:0]        id_ir;
   logic [ALUOP_W-1:0] id_alu_op;
   logic [CTRL_W-1:0]  id_ctrl;
   logic [DW-1:0]      id_rs_data;
   logic [DW-1:0]      id_rt_data;
   logic [DW-1:0]      id_imm;
   logic [DW-1:0]      id_pc4;
   logic               flush;
   logic               stall_o;

   logic               ex_valid;
   logic [ALUOP_W-1:0] ex_alu_op;
   logic [CTRL_W-1:0]  ex_ctrl;
   logic [DW-1:0]      ex_rs_data;
   logic [DW-1:0]      ex_rt_data;
   logic [DW-1:0]      ex_imm;
   logic [DW-1:0]      ex_pc4;
   logic [RW-1:0]      ex_rs;
   logic [RW-1:0]      ex_rt;
   logic [RW-1:0]      ex_rd;

   modport master (
      output id_ir, id_alu_op, id_ctrl, id_rs_data, id_rt_data, id_imm, id_pc4, flush,
      input  stall_o, ex_valid, ex_alu_op, ex_ctrl, ex_rs_data, ex_rt_data, ex_imm,
             ex_pc4, ex_rs, ex_rt, ex_rd
   );

   modport slave (
      input  id_ir, id_alu_op, id_ctrl, id_rs_data, id_rt_data, id_imm, id_pc4, flush,
      output stall_o, ex_valid, ex_alu_op, ex_ctrl, ex_rs_data, ex_rt_data, ex_imm,
             ex_pc4, ex_rs, ex_rt, ex_rd
   );

endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard: a valid load in EX whose rt is read by the ID instruction.
// Zero latency; $0 never causes a hazard.
module load_use_detect
   import mips_pkg::*;
#(
   parameter int RW = 5
) (
   input  logic          ex_valid,
   input  logic          ex_memread,
   input  logic [RW-1:0] ex_rt,
   input  logic [31:0]   id_ir,
   output logic          hazard
);

   logic [5:0]    id_op;
   logic [RW-1:0] id_rs;
   logic [RW-1:0] id_rt;
   logic          rs_match;
   logic          rt_match;
   logic          unused_ir;

   assign id_op     = id_ir[31:26];
   assign id_rs     = id_ir[21 +: RW];
   assign id_rt     = id_ir[16 +: RW];
   assign unused_ir = ^id_ir[15:0];

   assign rs_match = (ex_rt == id_rs);
   assign rt_match = uses_rt(id_op) && (ex_rt == id_rt);

   assign hazard = ex_valid && ex_memread && (ex_rt != '0) && (rs_match || rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and flush; one-cycle latency, stall_o holds PC and IF/ID.
// Optional perf counters (stall_cnt, bubble_cnt) when ID_EX_PERF_CNT_EN is defined.
module id_ex_stage
   import mips_pkg::*;
#(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   id_ex_stage_if.slave bus
`ifdef ID_EX_PERF_CNT_EN
   ,
   output logic [31:0]  stall_cnt,
   output logic [31:0]  bubble_cnt
`endif
);

   logic               valid_q;
   logic [ALUOP_W-1:0] alu_op_q;
   ctrl_t              ctrl_q;
   logic [DW-1:0]      rs_data_q;
   logic [DW-1:0]      rt_data_q;
   logic [DW-1:0]      imm_q;
   logic [DW-1:0]      pc4_q;
   logic [RW-1:0]      rs_q;
   logic [RW-1:0]      rt_q;
   logic [RW-1:0]      rd_q;

   logic hazard;
   logic id_nop;
   logic load_bubble;

   load_use_detect #(.RW(RW)) u_load_use_detect (
      .ex_valid   (valid_q),
      .ex_memread (ctrl_q.memread),
      .ex_rt      (rt_q),
      .id_ir      (bus.id_ir),
      .hazard     (hazard)
   );

   // Flush wins over the hazard: the instruction being held would be killed anyway.
   assign bus.stall_o = hazard && !bus.flush;
   assign id_nop      = (bus.id_ir == 32'd0);
   assign load_bubble = bus.flush || hazard || id_nop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         alu_op_q  <= '0;
         ctrl_q    <= '0;
         rs_data_q <= '0;
         rt_data_q <= '0;
         imm_q     <= '0;
         pc4_q     <= '0;
         rs_q      <= '0;
         rt_q      <= '0;
         rd_q      <= '0;
      end else if (load_bubble) begin
         valid_q   <= 1'b0;
         alu_op_q  <= '0;
         ctrl_q    <= '0;
         rs_data_q <= '0;
         rt_data_q <= '0;
         imm_q     <= '0;
         pc4_q     <= '0;
         rs_q      <= '0;
         rt_q      <= '0;
         rd_q      <= '0;
      end else begin
         valid_q   <= 1'b1;
         alu_op_q  <= bus.id_alu_op;
         ctrl_q    <= sanitize_ctrl(ctrl_t'(bus.id_ctrl));
         rs_data_q <= bus.id_rs_data;
         rt_data_q <= bus.id_rt_data;
         imm_q     <= bus.id_imm;
         pc4_q     <= bus.id_pc4;
         rs_q      <= bus.id_ir[21 +: RW];
         rt_q      <= bus.id_ir[16 +: RW];
         rd_q      <= bus.id_ir[11 +: RW];
      end
   end

   assign bus.ex_valid   = valid_q;
   assign bus.ex_alu_op  = alu_op_q;
   assign bus.ex_ctrl    = ctrl_q;
   assign bus.ex_rs_data = rs_data_q;
   assign bus.ex_rt_data = rt_data_q;
   assign bus.ex_imm     = imm_q;
   assign bus.ex_pc4     = pc4_q;
   assign bus.ex_rs      = rs_q;
   assign bus.ex_rt      = rt_q;
   assign bus.ex_rd      = rd_q;

`ifdef ID_EX_PERF_CNT_EN
   // Saturating event counters; they never wrap back to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (bus.stall_o && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
         if (load_bubble && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard/flush/reset scenarios followed by random traffic,
// every cycle compared against an instruction-level model of the EX slot.
module tb_id_ex_stage;
   import mips_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   id_ex_stage_if #(.DW(32), .RW(5)) bus ();

`ifdef ID_EX_PERF_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] bubble_cnt;
`endif

   id_ex_stage #(.DW(32), .RW(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef ID_EX_PERF_CNT_EN
      ,
      .stall_cnt  (stall_cnt),
      .bubble_cnt (bubble_cnt)
`endif
   );

   int checks = 0;
   int errors = 0;

   // Model of the instruction sitting in EX.
   logic        m_valid = 0;
   logic [2:0]  m_alu   = 0;
   logic [7:0]  m_ctrl  = 0;
   logic [31:0] m_rsd = 0, m_rtd = 0, m_imm = 0, m_pc4 = 0;
   logic [4:0]  m_rs = 0, m_rt = 0, m_rd = 0;
   logic [31:0] m_stalls = 0, m_bubbles = 0;
   bit          exp_stall = 0;

   localparam logic [7:0] XMASK  = 8'b0101_1011;
   localparam logic [7:0] CT_LW  = 8'h74;
   localparam logic [7:0] CT_ADD = 8'hC0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_hazard();
      logic [5:0] op;
      bit         src_rt;
      op     = bus.id_ir[31:26];
      src_rt = (op == 6'b000000) || (op == 6'b000100) || (op == 6'b101011);
      return (m_valid === 1'b1) && (m_ctrl[4] === 1'b1) && (m_rt != 5'd0) &&
             ((m_rt == bus.id_ir[25:21]) || (src_rt && (m_rt == bus.id_ir[20:16])));
   endfunction

   function automatic logic [7:0] m_clean(input logic [7:0] c);
      logic [7:0] r;
      r = c;
      for (int i = 0; i < 8; i++)
         if (XMASK[i] && (r[i] !== 1'b0) && (r[i] !== 1'b1)) r[i] = 1'b0;
      return r;
   endfunction

   task automatic m_clear();
      m_valid = 0; m_alu = 0; m_ctrl = 0;
      m_rsd = 0; m_rtd = 0; m_imm = 0; m_pc4 = 0;
      m_rs = 0; m_rt = 0; m_rd = 0;
   endtask

   always @(posedge clk or negedge rst_n) begin
      bit hz;
      if (!rst_n) begin
         m_clear();
         m_stalls  = 0;
         m_bubbles = 0;
      end else begin
         hz = m_hazard();
         if (hz && !bus.flush && (m_stalls != 32'hFFFF_FFFF)) m_stalls++;
         if (bus.flush || hz || (bus.id_ir == 32'd0)) begin
            if (m_bubbles != 32'hFFFF_FFFF) m_bubbles++;
            m_clear();
         end else begin
            m_valid = 1;
            m_alu   = bus.id_alu_op;
            m_ctrl  = m_clean(bus.id_ctrl);
            m_rsd   = bus.id_rs_data;
            m_rtd   = bus.id_rt_data;
            m_imm   = bus.id_imm;
            m_pc4   = bus.id_pc4;
            m_rs    = bus.id_ir[25:21];
            m_rt    = bus.id_ir[20:16];
            m_rd    = bus.id_ir[15:11];
         end
      end
   end

   always @(negedge clk) begin
      exp_stall = m_hazard() && !bus.flush;
      chk("stall_o",    bus.stall_o,    exp_stall);
      chk("ex_valid",   bus.ex_valid,   m_valid);
      chk("ex_alu_op",  bus.ex_alu_op,  m_alu);
      chk("ex_ctrl",    bus.ex_ctrl,    m_ctrl);
      chk("ex_rs_data", bus.ex_rs_data, m_rsd);
      chk("ex_rt_data", bus.ex_rt_data, m_rtd);
      chk("ex_imm",     bus.ex_imm,     m_imm);
      chk("ex_pc4",     bus.ex_pc4,     m_pc4);
      chk("ex_rs",      bus.ex_rs,      m_rs);
      chk("ex_rt",      bus.ex_rt,      m_rt);
      chk("ex_rd",      bus.ex_rd,      m_rd);
`ifdef ID_EX_PERF_CNT_EN
      chk("stall_cnt",  stall_cnt,  m_stalls);
      chk("bubble_cnt", bubble_cnt, m_bubbles);
`endif
   end

   function automatic logic [31:0] rtype(input int rs, input int rt, input int rd);
      return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 11'h020};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt);
      return {op, 5'(rs), 5'(rt), 16'($urandom)};
   endfunction

   task automatic drive(input logic [31:0] ir, input logic [7:0] ctrl,
                        input logic [2:0] alu, input logic fl);
      bus.id_ir      = ir;
      bus.id_ctrl    = ctrl;
      bus.id_alu_op  = alu;
      bus.flush      = fl;
      bus.id_rs_data = $urandom;
      bus.id_rt_data = $urandom;
      bus.id_imm     = $urandom;
      bus.id_pc4     = $urandom;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [5:0] ops [6];
      logic [5:0] op;
      ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
      drive(32'd0, 8'd0, 3'd0, 1'b0);
      #1 rst_n = 1'b0;

      // Reset with live random inputs, then first capture one edge after release.
      for (int i = 0; i < 3; i++) begin
         drive($urandom, $urandom, 3'($urandom), 1'($urandom));
         tick();
         chk("rst_ex_valid", bus.ex_valid, 1'b0);
         chk("rst_ex_rs_data", bus.ex_rs_data, 32'd0);
         chk("rst_stall", bus.stall_o, 1'b0);
      end
      drive(rtype(1, 4, 3), CT_ADD, 3'd2, 1'b0);
      rst_n = 1'b1;
      tick();
      chk("post_rst_valid", bus.ex_valid, 1'b1);
      chk("post_rst_rd", bus.ex_rd, 5'd3);

      // Three load-use stalls: lw $2,0($1) ; add $3,$2,$4.
      for (int i = 0; i < 3; i++) begin
         drive(itype(LW, 1, 2), CT_LW, 3'd0, 1'b0);
         tick();
         chk("lw_ctrl", bus.ex_ctrl, CT_LW);
         drive(rtype(2, 4, 3), CT_ADD, 3'd2, 1'b0);
         #1 chk("lu_stall", bus.stall_o, 1'b1);
         tick();
         chk("lu_bubble_valid", bus.ex_valid, 1'b0);
         chk("lu_bubble_ctrl", bus.ex_ctrl, 8'd0);
         #1 chk("lu_stall_clear", bus.stall_o, 1'b0);
         tick();
         chk("lu_add_valid", bus.ex_valid, 1'b1);
         chk("lu_add_rs", bus.ex_rs, 5'd2);
      end

      // Two flushes, the second coinciding with a load-use hazard.
      drive(rtype(1, 4, 3), CT_ADD, 3'd2, 1'b1);
      tick();
      chk("flush_valid", bus.ex_valid, 1'b0);
      drive(itype(LW, 1, 2), CT_LW, 3'd0, 1'b0);
      tick();
      drive(rtype(2, 4, 3), CT_ADD, 3'd2, 1'b1);
      #1 chk("flush_hz_stall", bus.stall_o, 1'b0);
      tick();
      chk("flush_hz_valid", bus.ex_valid, 1'b0);
`ifdef ID_EX_PERF_CNT_EN
      chk("perf_stall_cnt", stall_cnt, 32'd3);
      chk("perf_bubble_cnt", bubble_cnt, 32'd5);
`endif

      // No false stalls: $0 target, and a load whose rt is a destination.
      drive(itype(LW, 1, 0), CT_LW, 3'd0, 1'b0);
      tick();
      drive(rtype(0, 0, 3), CT_ADD, 3'd2, 1'b0);
      #1 chk("zero_reg_stall", bus.stall_o, 1'b0);
      tick();
      drive(itype(LW, 1, 5), CT_LW, 3'd0, 1'b0);
      tick();
      drive(itype(LW, 7, 5), CT_LW, 3'd0, 1'b0);
      #1 chk("lw_rt_dest_stall", bus.stall_o, 1'b0);
      tick();
      // EX now holds lw $5; sw reads rt=$5, so it must stall.
      drive(itype(SW, 1, 5), 8'h28, 3'd0, 1'b0);
      #1 chk("sw_rt_stall", bus.stall_o, 1'b1);
      tick();

      // sw with unknown RegDest/MemToReg/Branch from the control unit.
      drive(itype(SW, 1, 9), {1'bx, 1'b0, 1'b1, 1'b0, 1'b1, 1'bx, 1'bx, 1'b0}, 3'd0, 1'b0);
      tick();
      chk("sw_valid", bus.ex_valid, 1'b1);
      chk("sw_memwrite", bus.ex_ctrl[CTRL_MEMWRITE], 1'b1);

      // NOP with garbage control is still a bubble.
      drive(32'd0, 8'hFF, 3'd7, 1'b0);
      tick();
      chk("nop_valid", bus.ex_valid, 1'b0);
      chk("nop_ctrl", bus.ex_ctrl, 8'd0);
      chk("nop_alu", bus.ex_alu_op, 3'd0);

      // Reset arriving mid-stall drops the bubble; no stall after release.
      drive(itype(LW, 1, 2), CT_LW, 3'd0, 1'b0);
      tick();
      drive(rtype(2, 4, 3), CT_ADD, 3'd2, 1'b0);
      #1 chk("mid_stall", bus.stall_o, 1'b1);
      rst_n = 1'b0;
      #1 chk("mid_rst_stall", bus.stall_o, 1'b0);
      chk("mid_rst_ctrl", bus.ex_ctrl, 8'd0);
      tick();
      rst_n = 1'b1;
      #1 chk("mid_rel_stall", bus.stall_o, 1'b0);
      tick();
      chk("mid_rel_valid", bus.ex_valid, 1'b1);
      chk("mid_rel_rs", bus.ex_rs, 5'd2);

      // Random traffic; upstream holds ID whenever the model says it stalled.
      for (int n = 0; n < 2000; n++) begin
         bit held;
         held = exp_stall && rst_n;
         tick();
         rst_n = ($urandom_range(0, 49) != 0);
         if (held) begin
            bus.flush = ($urandom_range(0, 9) == 0);
         end else begin
            op = ops[$urandom_range(0, 5)];
            if ($urandom_range(0, 11) == 0)
               drive(32'd0, $urandom, 3'($urandom), 1'b0);
            else
               drive({op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), 11'($urandom)},
                     {3'($urandom), (op == LW), 4'($urandom)},
                     3'($urandom), 1'b0);
            bus.flush = ($urandom_range(0, 9) == 0);
         end
      end

      rst_n = 1'b1;
      repeat (3) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      errors++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the 5-stage MIPS pipeline. Sits directly downstream of the decode control unit and register file.
- Registers the decoded control bundle, operands and instruction fields into EX.
- Contains load-use hazard detection: stalls PC and IF/ID, injects a bubble into EX.
- Honours a branch/jump flush from later stages.

Parameters:
- DW, 32, datapath width (operands, immediate, PC+4)
- RW, 5, register index width

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_ir  in  32  instruction in ID; opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11]
- id_alu_op  in  3  ALUOp from control unit
- id_ctrl  in  8  {RegDest,RegWrite,ALUSrc,MemRead,MemWrite,MemToReg,Branch,Jump}, bit 7 = RegDest
- id_rs_data, id_rt_data  in  DW  register file read data
- id_imm  in  DW  sign-extended immediate
- id_pc4  in  DW  PC+4 of ID instruction
- flush  in  1  branch/jump taken: kill ID instruction
- stall_o  out  1  hold PC and IF/ID this cycle (combinational)
- ex_valid  out  1  EX slot holds a real instruction
- ex_alu_op  out  3
- ex_ctrl  out  8
- ex_rs_data, ex_rt_data, ex_imm, ex_pc4  out  DW
- ex_rs, ex_rt, ex_rd  out  RW

Behaviour:
- Reset (async, rst_n=0): every registered output = 0. stall_o is driven from registered state, so it is 0 while in reset.
- Latency: one cycle. ID values on edge N appear on ex_* after edge N.
- id_uses_rt = opcode in {000000 R-type, 000100 beq, 101011 sw}.
- Hazard condition:
  - hazard = ex_valid & ex_ctrl.MemRead & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)).
  - stall_o = hazard & ~flush.
- Priority per edge: flush > hazard > normal.
  - flush: load bubble (ex_valid=0, ex_ctrl=0, ex_alu_op=0; data/index fields = 0).
  - hazard: load the same bubble. Upstream holds the ID instruction, so it re-evaluates next cycle. The hazard clears after exactly one bubble, because the bubble has MemRead=0.
  - normal: capture all ID fields. ex_valid = (id_ir != 0).
- NOP (id_ir == 0): captured as a bubble. ex_ctrl and ex_alu_op are forced to 0 regardless of input.
- X-sanitising: the control unit drives X on don't-care bits for sw and j.
  - On capture, ex_ctrl bits RegWrite, MemRead, MemWrite, Branch and Jump are masked to 0 when X/Z. Use the `(^bit === 1'bx)` test in simulation. Synthesis sees a plain register.
  - The other bits pass through unchanged.
- Reset mid-stall: the bubble is lost and all outputs go to 0. No stall persists after rst_n rises.
- No multi-cycle state beyond the pipeline register. Back-to-back loads each incur at most one stall cycle.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- With it defined:
  - extra ports: stall_cnt out 32 and bubble_cnt out 32.
  - stall_cnt increments on each edge where stall_o=1.
  - bubble_cnt increments on each edge where a bubble is loaded (flush, hazard or NOP).
  - Both saturate at 0xFFFFFFFF. Async reset to 0.
- Without it: the ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants (RTYPE, LW, SW, BEQ, J)
  - ctrl bit-index localparams (CTRL_REGDST=7 … CTRL_JUMP=0)
  - CTRL_W=8, ALUOP_W=3
  - a ctrl bundle packed typedef
- One sub-module: load_use_detect. It is combinational, produces hazard from ex_* and id_ir, and is reused by the forwarding unit bench.

Test Plan:
- Reset: hold rst_n=0 mid-stream with random inputs → all ex_* =0, stall_o=0. After release, the first capture appears one cycle later.
- Load-use: lw $2,0($1) in EX; add $3,$2,$4 in ID → stall_o=1 for exactly 1 cycle and ex_valid=0 next cycle. The add is captured on the following edge with ex_rs=2.
- No false stall:
  - lw $0 in EX with add using $0 → stall_o=0.
  - lw $5 in EX with lw $6,0($7) in ID (rt not a source) → stall_o=0.
- Flush priority: hazard and flush=1 on the same cycle → stall_o=0, bubble loaded, ex_valid=0.
- X-sanitise and NOP:
  - sw with id_ctrl Branch/RegDest = X → ex_ctrl Branch=0, MemWrite=1.
  - id_ir=0 → ex_valid=0, ex_ctrl=0.
- Perf counters (ID_EX_PERF_CNT_EN): 3 load-use stalls and 2 flushes → stall_cnt=3, bubble_cnt=5.
